// File: rtl/aes_cbc_stream_arbiter.sv
// aes_cbc_stream_arbiter: shares one aes256_cbc_iter core between
// NUM_CHANNELS AXI-Stream requesters, granting one whole packet at a time.
// Ports:
//   Clk, Rst               clock, synchronous active-high reset
//   S_axis_*  (per chan)   requester input streams (data at [i*128 +: 128])
//   M_axis_*               per-channel valid/ready, shared data/keep/last
//   Core_s_axis_*          beats forwarded to the core's input stream
//   Core_m_axis_*          core output stream, routed to the granted channel
//   Busy, Grant_id         arbiter status (Grant_id is 0 while idle)
module aes_cbc_stream_arbiter #(
    parameter  int NUM_CHANNELS = 4,
    localparam int CH_WIDTH     = $clog2(NUM_CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_CHANNELS-1:0]   S_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]   S_axis_tready,
    input  logic [NUM_CHANNELS*128-1:0] S_axis_tdata,
    input  logic [NUM_CHANNELS*16-1:0]  S_axis_tkeep,
    input  logic [NUM_CHANNELS-1:0]   S_axis_tlast,
    input  logic [NUM_CHANNELS-1:0]   S_axis_tuser,
    output logic [NUM_CHANNELS-1:0]   M_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]   M_axis_tready,
    output logic [127:0]              M_axis_tdata,
    output logic [15:0]               M_axis_tkeep,
    output logic                      M_axis_tlast,
    output logic                      Core_s_axis_tvalid,
    input  logic                      Core_s_axis_tready,
    output logic [127:0]              Core_s_axis_tdata,
    output logic [15:0]               Core_s_axis_tkeep,
    output logic                      Core_s_axis_tlast,
    output logic                      Core_s_axis_tuser,
    input  logic                      Core_m_axis_tvalid,
    output logic                      Core_m_axis_tready,
    input  logic [127:0]              Core_m_axis_tdata,
    input  logic [15:0]               Core_m_axis_tkeep,
    input  logic                      Core_m_axis_tlast,
    output logic                      Busy,
    output logic [CH_WIDTH-1:0]       Grant_id
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_FORWARD = 3'b010,
        ST_DRAIN   = 3'b100
    } state_t;

    state_t              state, state_nx;
    logic [CH_WIDTH-1:0] rr_ptr, rr_ptr_nx;
    logic [CH_WIDTH-1:0] grant, grant_nx;
    logic [CH_WIDTH-1:0] pick;
    logic [1:0]          beat_cnt, beat_cnt_nx;
    logic                any_req;
    logic                in_hs;
    logic                out_end;

    // Round-robin search: walk downward so the lowest offset from rr_ptr wins.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (S_axis_tvalid[(int'(rr_ptr) + k) % NUM_CHANNELS]) begin
                pick    = CH_WIDTH'((int'(rr_ptr) + k) % NUM_CHANNELS);
                any_req = 1'b1;
            end
        end
    end

    // Datapath muxing between the granted channel and the core.
    always_comb begin
        S_axis_tready      = '0;
        M_axis_tvalid      = '0;
        M_axis_tdata       = '0;
        M_axis_tkeep       = '0;
        M_axis_tlast       = 1'b0;
        Core_s_axis_tvalid = 1'b0;
        Core_s_axis_tdata  = '0;
        Core_s_axis_tkeep  = '0;
        Core_s_axis_tlast  = 1'b0;
        Core_s_axis_tuser  = 1'b0;
        Core_m_axis_tready = 1'b0;
        if (state == ST_FORWARD) begin
            Core_s_axis_tvalid   = S_axis_tvalid[grant];
            Core_s_axis_tdata    = S_axis_tdata[int'(grant)*128 +: 128];
            Core_s_axis_tkeep    = S_axis_tkeep[int'(grant)*16 +: 16];
            // Key and IV beats never carry tlast toward the core.
            Core_s_axis_tlast    = S_axis_tlast[grant] && (beat_cnt == 2'd3);
            Core_s_axis_tuser    = S_axis_tuser[grant];
            S_axis_tready[grant] = Core_s_axis_tready;
        end
        if (state != ST_IDLE) begin
            M_axis_tvalid[grant] = Core_m_axis_tvalid;
            Core_m_axis_tready   = M_axis_tready[grant];
            if (Core_m_axis_tvalid) begin
                M_axis_tdata = Core_m_axis_tdata;
                M_axis_tkeep = Core_m_axis_tkeep;
                M_axis_tlast = Core_m_axis_tlast;
            end
        end
    end

    assign in_hs   = (state == ST_FORWARD) && S_axis_tvalid[grant]
                     && Core_s_axis_tready;
    assign out_end = (state == ST_DRAIN) && Core_m_axis_tvalid
                     && M_axis_tready[grant] && Core_m_axis_tlast;

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        grant_nx    = grant;
        beat_cnt_nx = beat_cnt;
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_nx = pick;
                    state_nx = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                if (in_hs) begin
                    if (beat_cnt != 2'd3) begin
                        beat_cnt_nx = beat_cnt + 2'd1;
                    end else if (S_axis_tlast[grant]) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_end) begin
                    rr_ptr_nx   = (grant == CH_WIDTH'(NUM_CHANNELS - 1))
                                  ? '0 : grant + 1'b1;
                    grant_nx    = '0;
                    beat_cnt_nx = 2'd0;
                    state_nx    = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            beat_cnt <= 2'd0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_ptr_nx;
            grant    <= grant_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    assign Busy     = (state != ST_IDLE);
    assign Grant_id = grant;

endmodule
